// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the
// shared single-ported memory (including the address/write-data mux select).
interface dmem_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_done;
    logic [31:0] a_rdata;

    logic        b_req;
    logic        b_we;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_done;
    logic [31:0] b_rdata;

    logic        mux_sel;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    // arbiter side
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_rdata,
        output a_done, a_rdata, b_done, b_rdata,
        output mux_sel, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // requester / memory side
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_rdata,
        input  a_done, a_rdata, b_done, b_rdata,
        input  mux_sel, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between port A (CPU) and port B
// (DMA/debug); each access is a fixed MEM_LAT-cycle transaction.
module dmem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             grant_a;
    logic             grant_b;

    logic             mux_sel;
    logic             mem_en;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             a_done;
    logic             b_done;
    logic [31:0]      a_rdata;
    logic [31:0]      b_rdata;

    // last_grant=1 means A was served last, so B wins the next tie
    always_comb begin
        grant_a = bus.a_req & (~bus.b_req | ~last_grant);
        grant_b = bus.b_req & ~grant_a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b0;
            mux_sel    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            a_done     <= 1'b0;
            b_done     <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    a_done <= 1'b0;
                    b_done <= 1'b0;
                    if (grant_a) begin
                        mem_addr   <= bus.a_addr;
                        mem_wdata  <= bus.a_wdata;
                        mem_we     <= bus.a_we;
                        mux_sel    <= 1'b1;
                        mem_en     <= 1'b1;
                        cnt        <= CNT_W'(MEM_LAT - 1);
                        last_grant <= 1'b1;
                        state      <= BUSY;
                    end else if (grant_b) begin
                        mem_addr   <= bus.b_addr;
                        mem_wdata  <= bus.b_wdata;
                        mem_we     <= bus.b_we;
                        mux_sel    <= 1'b0;
                        mem_en     <= 1'b1;
                        cnt        <= CNT_W'(MEM_LAT - 1);
                        last_grant <= 1'b0;
                        state      <= BUSY;
                    end else begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // mem_rdata is valid in this last BUSY cycle
                        if (!mem_we) begin
                            if (mux_sel) a_rdata <= bus.mem_rdata;
                            else         b_rdata <= bus.mem_rdata;
                        end
                        a_done <= mux_sel;
                        b_done <= ~mux_sel;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    a_done <= 1'b0;
                    b_done <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    a_done <= 1'b0;
                    b_done <= 1'b0;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.mux_sel   = mux_sel;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.a_done    = a_done;
    assign bus.b_done    = b_done;
    assign bus.a_rdata   = a_rdata;
    assign bus.b_rdata   = b_rdata;
    assign bus.busy      = (state != IDLE);

endmodule
